// File: rtl/engine_oil_filter.sv
// Moving-average conditioning stage for raw engine-oil level samples.
// Tracks a full/filling window and flags a sensor that stops sending.
module engine_oil_filter #(
  parameter int AVG_LOG2 = 3,
  parameter int TIMEOUT  = 1000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               sample_valid,
  input  logic signed [31:0] sample,
  output logic signed [31:0] engine_oil,
  output logic               oil_valid,
  output logic               sensor_fault
);

  localparam int N  = 2 ** AVG_LOG2;
  localparam int AW = 32 + AVG_LOG2;
  localparam int IW = $clog2(TIMEOUT + 1);
  localparam int FW = AVG_LOG2 + 1;

  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);
  localparam logic [IW-1:0] IDLE_MAX  = IW'(TIMEOUT);
  localparam logic [FW-1:0] FILL_LAST = FW'(N - 1);
  localparam logic [FW-1:0] FILL_MAX  = FW'(N);

  typedef enum logic [1:0] {
    FILL,
    RUN,
    FAULT
  } state_t;

  state_t state, state_next;

  logic signed [31:0]   mem [N];
  logic [AVG_LOG2-1:0]  wr_ptr;
  logic [FW-1:0]        fill_cnt;
  logic signed [AW-1:0] acc, acc_next;
  logic [IW-1:0]        idle_cnt;
  logic signed [31:0]   old;
  logic                 accept, recover, timeout;

  assign old = mem[wr_ptr];

  // Running sum with the new sample in and the oldest slot out.
  always_comb begin
    acc_next = acc
             + $signed({{AVG_LOG2{sample[31]}}, sample})
             - $signed({{AVG_LOG2{old[31]}}, old});
  end

  // Next state and per-cycle action decode.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    recover    = 1'b0;
    timeout    = 1'b0;
    unique case (state)
      FILL, RUN: begin
        if (sample_valid) accept = 1'b1;
        else if (idle_cnt == IDLE_LAST) timeout = 1'b1;
        if (timeout) state_next = FAULT;
        else if (accept && state == FILL && fill_cnt == FILL_LAST)
          state_next = RUN;
      end
      FAULT: begin
        if (sample_valid) begin
          recover    = 1'b1;
          state_next = FILL;
        end
      end
      default: state_next = FILL;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= FILL;
    else       state <= state_next;
  end

  // Window storage, running sum, counters and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < N; i++) mem[i] <= '0;
      acc          <= '0;
      wr_ptr       <= '0;
      fill_cnt     <= '0;
      idle_cnt     <= '0;
      engine_oil   <= '0;
      oil_valid    <= 1'b0;
      sensor_fault <= 1'b0;
    end else begin
      if (recover) begin
        for (int i = 0; i < N; i++) mem[i] <= '0;
        mem[0]     <= sample;
        acc        <= {{AVG_LOG2{sample[31]}}, sample};
        wr_ptr     <= AVG_LOG2'(1);
        fill_cnt   <= FW'(1);
        idle_cnt   <= '0;
        engine_oil <= sample >>> AVG_LOG2;
      end else if (accept) begin
        mem[wr_ptr] <= sample;
        acc         <= acc_next;
        wr_ptr      <= wr_ptr + AVG_LOG2'(1);
        if (fill_cnt != FILL_MAX) fill_cnt <= fill_cnt + FW'(1);
        idle_cnt    <= '0;
        engine_oil  <= acc_next[AW-1:AVG_LOG2];
      end else if (state != FAULT && idle_cnt != IDLE_MAX) begin
        idle_cnt <= idle_cnt + IW'(1);
      end
      oil_valid    <= (state_next == RUN);
      sensor_fault <= (state_next == FAULT);
    end
  end

endmodule

// File: tb/tb_engine_oil_filter.sv
// Bench for engine_oil_filter: directed scenarios plus random traffic,
// all checked against a queue-based window model.
module tb_engine_oil_filter;

  localparam int LOG2 = 3;
  localparam int N    = 8;
  localparam int TO   = 20;

  logic               clock;
  logic               reset;
  logic               sample_valid;
  logic signed [31:0] sample;
  logic signed [31:0] engine_oil;
  logic               oil_valid;
  logic               sensor_fault;

  int total = 0;
  int bad   = 0;

  // model state
  longint win[$];
  int     m_idle;
  bit     m_fault;
  bit     m_valid;
  longint m_oil;

  engine_oil_filter #(
    .AVG_LOG2(LOG2),
    .TIMEOUT (TO)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .sample_valid(sample_valid),
    .sample      (sample),
    .engine_oil  (engine_oil),
    .oil_valid   (oil_valid),
    .sensor_fault(sensor_fault)
  );

  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  function automatic longint floor_div(input longint s);
    longint q;
    q = s / N;
    if ((s % N) != 0 && s < 0) q = q - 1;
    return q;
  endfunction

  function automatic longint win_sum();
    longint s = 0;
    foreach (win[i]) s += win[i];
    return s;
  endfunction

  task automatic model_reset();
    win.delete();
    m_idle  = 0;
    m_fault = 0;
    m_valid = 0;
    m_oil   = 0;
  endtask

  task automatic model_cycle(input bit v, input longint s);
    if (m_fault) begin
      if (v) begin
        win.delete();
        win.push_back(s);
        m_fault = 0;
        m_idle  = 0;
        m_valid = 0;
        m_oil   = floor_div(s);
      end
    end else if (v) begin
      win.push_back(s);
      if (win.size() > N) void'(win.pop_front());
      m_idle  = 0;
      m_valid = (win.size() == N);
      m_oil   = floor_div(win_sum());
    end else begin
      m_idle++;
      if (m_idle >= TO) begin
        m_fault = 1;
        m_valid = 0;
      end
    end
  endtask

  task automatic step(input bit v, input logic signed [31:0] s);
    sample_valid = v;
    sample       = v ? s : $urandom;
    @(posedge clock);
    #1;
    model_cycle(v, longint'(s));
    sample_valid = 0;
  endtask

  task automatic do_reset(input int cycles);
    reset        = 1;
    sample_valid = 0;
    repeat (cycles) @(posedge clock);
    #1;
    reset = 0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset(15);
    total++;
    if (engine_oil !== 32'sd0 || oil_valid !== 1'b0 || sensor_fault !== 1'b0) begin
      bad++;
      $display("FAIL reset: got oil=%0d valid=%b fault=%b want 0 0 0",
               engine_oil, oil_valid, sensor_fault);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < N; i++) begin
      step(1, 32'sd10);
      total++;
      if (engine_oil !== 32'(m_oil) || oil_valid !== m_valid) begin
        bad++;
        $display("FAIL fill[%0d]: got oil=%0d valid=%b want oil=%0d valid=%b",
                 i, engine_oil, oil_valid, m_oil, m_valid);
      end
    end
    total++;
    if (engine_oil !== 32'sd10 || oil_valid !== 1'b1) begin
      bad++;
      $display("FAIL fill_end: got oil=%0d valid=%b want 10 1",
               engine_oil, oil_valid);
    end
  endtask

  task automatic test_dip();
    step(1, 32'sd9);
    total++;
    if (engine_oil !== 32'sd9 || oil_valid !== 1'b1) begin
      bad++;
      $display("FAIL dip: got oil=%0d valid=%b want 9 1", engine_oil, oil_valid);
    end
    for (int i = 0; i < N; i++) begin
      step(1, 32'sd10);
      total++;
      if (engine_oil !== 32'(m_oil) || oil_valid !== 1'b1) begin
        bad++;
        $display("FAIL dip_refill[%0d]: got oil=%0d valid=%b want oil=%0d valid=1",
                 i, engine_oil, oil_valid, m_oil);
      end
    end
    total++;
    if (engine_oil !== 32'sd10) begin
      bad++;
      $display("FAIL dip_end: got oil=%0d want 10", engine_oil);
    end
  endtask

  task automatic test_negative();
    do_reset(2);
    repeat (N) step(1, -32'sd1);
    total++;
    if (engine_oil !== -32'sd1 || oil_valid !== 1'b1) begin
      bad++;
      $display("FAIL neg_full: got oil=%0d valid=%b want -1 1",
               engine_oil, oil_valid);
    end
    step(1, 32'sd0);
    total++;
    if (engine_oil !== -32'sd1 || engine_oil !== 32'(m_oil)) begin
      bad++;
      $display("FAIL neg_floor: got oil=%0d want -1", engine_oil);
    end
  endtask

  task automatic test_timeout();
    do_reset(2);
    repeat (N) step(1, 32'sd30);
    for (int i = 1; i < TO; i++) begin
      step(0, 0);
      total++;
      if (sensor_fault !== 1'b0 || oil_valid !== 1'b1) begin
        bad++;
        $display("FAIL idle[%0d]: got fault=%b valid=%b want 0 1",
                 i, sensor_fault, oil_valid);
      end
    end
    step(0, 0);
    total++;
    if (sensor_fault !== 1'b1 || oil_valid !== 1'b0 || engine_oil !== 32'sd30) begin
      bad++;
      $display("FAIL timeout: got fault=%b valid=%b oil=%0d want 1 0 30",
               sensor_fault, oil_valid, engine_oil);
    end
    repeat (3) step(0, 0);
    total++;
    if (sensor_fault !== 1'b1 || engine_oil !== 32'sd30) begin
      bad++;
      $display("FAIL fault_hold: got fault=%b oil=%0d want 1 30",
               sensor_fault, engine_oil);
    end
  endtask

  task automatic test_recovery();
    step(1, 32'sd16);
    total++;
    if (sensor_fault !== 1'b0 || oil_valid !== 1'b0 || engine_oil !== 32'sd2) begin
      bad++;
      $display("FAIL recover: got fault=%b valid=%b oil=%0d want 0 0 2",
               sensor_fault, oil_valid, engine_oil);
    end
    for (int i = 0; i < N - 1; i++) begin
      step(1, 32'sd16);
      total++;
      if (engine_oil !== 32'(m_oil) || oil_valid !== m_valid) begin
        bad++;
        $display("FAIL recover_fill[%0d]: got oil=%0d valid=%b want oil=%0d valid=%b",
                 i, engine_oil, oil_valid, m_oil, m_valid);
      end
    end
    total++;
    if (engine_oil !== 32'sd16 || oil_valid !== 1'b1) begin
      bad++;
      $display("FAIL recover_end: got oil=%0d valid=%b want 16 1",
               engine_oil, oil_valid);
    end
  endtask

  task automatic test_near_timeout();
    do_reset(2);
    repeat (N) step(1, 32'sd30);
    repeat (TO - 1) step(0, 0);
    step(1, 32'sd30);
    total++;
    if (sensor_fault !== 1'b0 || oil_valid !== 1'b1) begin
      bad++;
      $display("FAIL last_cycle_sample: got fault=%b valid=%b want 0 1",
               sensor_fault, oil_valid);
    end
    repeat (TO - 1) step(0, 0);
    total++;
    if (sensor_fault !== 1'b0) begin
      bad++;
      $display("FAIL idle_restart: got fault=%b want 0", sensor_fault);
    end
  endtask

  task automatic test_reset_mid_fill();
    do_reset(2);
    repeat (5) step(1, 32'sd40);
    do_reset(1);
    total++;
    if (engine_oil !== 32'sd0 || oil_valid !== 1'b0 || sensor_fault !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset: got oil=%0d valid=%b fault=%b want 0 0 0",
               engine_oil, oil_valid, sensor_fault);
    end
    repeat (N) step(1, 32'sd8);
    total++;
    if (engine_oil !== 32'sd8 || oil_valid !== 1'b1) begin
      bad++;
      $display("FAIL mid_reset_refill: got oil=%0d valid=%b want 8 1",
               engine_oil, oil_valid);
    end
  endtask

  task automatic test_random();
    int gap;
    logic signed [31:0] s;
    do_reset(2);
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 30) == 0) begin
        gap = $urandom_range(TO - 2, TO + 3);
        repeat (gap) begin
          step(0, 0);
          total++;
          if (sensor_fault !== m_fault || oil_valid !== m_valid ||
              engine_oil !== 32'(m_oil)) begin
            bad++;
            $display("FAIL rand_gap[%0d]: got oil=%0d valid=%b fault=%b want %0d %b %b",
                     i, engine_oil, oil_valid, sensor_fault, m_oil, m_valid, m_fault);
          end
        end
      end
      s = ($urandom_range(0, 1) == 1) ? $signed($urandom)
                                      : $signed(32'($urandom_range(0, 200)) - 32'sd100);
      step($urandom_range(0, 3) != 0, s);
      total++;
      if (sensor_fault !== m_fault || oil_valid !== m_valid ||
          engine_oil !== 32'(m_oil)) begin
        bad++;
        $display("FAIL rand[%0d]: got oil=%0d valid=%b fault=%b want %0d %b %b",
                 i, engine_oil, oil_valid, sensor_fault, m_oil, m_valid, m_fault);
      end
    end
  endtask

  initial begin
    reset        = 1;
    sample_valid = 0;
    sample       = '0;
    model_reset();
    test_reset();
    test_fill();
    test_dip();
    test_negative();
    test_timeout();
    test_recovery();
    test_near_timeout();
    test_reset_mid_fill();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
